// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute/halt sequencer driving the datapath register
// enables, mux selects, ALU function and memory strobes.
// Optional build macro MU0_INSTR_COUNT_EN adds a 16-bit retired-instruction counter.
module mu0_control (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  input  logic        Mem_Ready,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic [1:0]  ALU_fs,
  output logic        ACC_En,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Rd,
  output logic        Wr,
  output logic        Fetch,
`ifdef MU0_INSTR_COUNT_EN
  output logic [15:0] Instr_Count,
`endif
  output logic        Halted
);

  localparam logic [1:0] StFetch = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam logic [1:0] AluPassY = 2'b00;
  localparam logic [1:0] AluAdd   = 2'b01;
  localparam logic [1:0] AluInc   = 2'b10;
  localparam logic [1:0] AluSub   = 2'b11;

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpSta = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpJmp = 4'h4;
  localparam logic [3:0] OpJge = 4'h5;
  localparam logic [3:0] OpJne = 4'h6;
  localparam logic [3:0] OpStp = 4'h7;

  logic [1:0] state_q, state_d;
  logic       exec_mem_op;

  // Opcodes 0-3 touch memory and must wait for Mem_Ready in EXEC
  assign exec_mem_op = (F[3:2] == 2'b00);

  // Next-state logic; a memory access stalls the current state until Mem_Ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (Mem_Ready) state_d = StExec;
      end
      StExec: begin
        if (!exec_mem_op || Mem_Ready) begin
          state_d = (F == OpStp) ? StHalt : StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Output decode; register enables are qualified by Mem_Ready on memory cycles
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fs   = AluPassY;
    ACC_En   = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Fetch    = (state_q == StFetch);
    Halted   = (state_q == StHalt);
    case (state_q)
      StFetch: begin
        Rd     = 1'b1;
        X_sel  = 1'b1;
        ALU_fs = AluInc;
        IR_En  = Mem_Ready;
        PC_En  = Mem_Ready;
      end
      StExec: begin
        Addr_sel = 1'b1;
        case (F)
          OpLda: begin
            Rd     = 1'b1;
            ALU_fs = AluPassY;
            ACC_En = Mem_Ready;
          end
          OpSta: begin
            Wr = 1'b1;
          end
          OpAdd: begin
            Rd     = 1'b1;
            ALU_fs = AluAdd;
            ACC_En = Mem_Ready;
          end
          OpSub: begin
            Rd     = 1'b1;
            ALU_fs = AluSub;
            ACC_En = Mem_Ready;
          end
          OpJmp: begin
            Y_sel = 1'b1;
            PC_En = 1'b1;
          end
          OpJge: begin
            Y_sel = 1'b1;
            PC_En = ~N;
          end
          OpJne: begin
            Y_sel = 1'b1;
            PC_En = ~Z;
          end
          default: ;  // STP and NOPs: no enables, no memory access
        endcase
      end
      default: ;
    endcase
    // Reset suppresses every side effect and parks the selects at 0
    if (Reset) begin
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      ALU_fs   = AluPassY;
      ACC_En   = 1'b0;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Rd       = 1'b0;
      Wr       = 1'b0;
    end
  end

`ifdef MU0_INSTR_COUNT_EN
  logic [15:0] count_q;
  logic        exec_done;

  assign exec_done   = (state_q == StExec) && (state_d != StExec);
  assign Instr_Count = count_q;

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge Clk) begin
    if (Reset)          count_q <= 16'h0000;
    else if (exec_done) count_q <= count_q + 16'h0001;
  end
`endif

endmodule
